// File: rtl/program_loader_if.sv
// UART byte input and program-memory write bus of program_loader.
// The loader uses the master modport. The UART/RAM side uses the slave modport.
interface program_loader_if #(
    parameter int ADDR_W = 10
) ();
    logic [7:0]        i_rx_data;
    logic              i_rx_done;
    logic              o_wr_en;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [15:0]       o_wr_data;

    modport master (
        input  i_rx_data, i_rx_done,
        output o_wr_en, o_wr_addr, o_wr_data
    );

    modport slave (
        output i_rx_data, i_rx_done,
        input  o_wr_en, o_wr_addr, o_wr_data
    );
endinterface

// File: rtl/program_loader.sv
// Assembles UART bytes into {opcode, operand} words, writes them to program RAM and releases the CPU on HALT.
// Optional macro LOADER_CHECKSUM_EN: a trailing XOR-checksum byte must match before DONE.
module program_loader #(
    parameter int N_OP    = 5,
    parameter int N_OPRND = 11,
    parameter int ADDR_W  = 10
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    program_loader_if.master  bus,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_cpu_start,
    output logic              o_error,
    output logic [ADDR_W:0]   o_word_count
);
    localparam int                W         = N_OP + N_OPRND;
    localparam logic [N_OP-1:0]   OP_HALT   = '0;
    localparam logic [N_OP-1:0]   OP_MAX    = N_OP'(7);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_HI,
        S_WAIT_LO,
        S_WRITE,
`ifdef LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERROR
    } state_t;

    state_t            r_state;
    logic [7:0]        r_hi;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_count;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [W-1:0]      r_wr_data;
    logic              r_busy;
    logic              r_done;
    logic              r_cpu_start;
    logic              r_error;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        r_chk;
`endif

    logic [N_OP-1:0]   w_rx_op;
    logic [N_OP-1:0]   w_hi_op;

    assign w_rx_op = bus.i_rx_data[7 -: N_OP];
    assign w_hi_op = r_hi[7 -: N_OP];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_hi        <= '0;
            r_addr      <= '0;
            r_count     <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cpu_start <= 1'b0;
            r_error     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_chk       <= '0;
`endif
        end else begin
            r_wr_en     <= 1'b0;
            r_cpu_start <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (i_start) begin
                        r_state <= S_WAIT_HI;
                        r_addr  <= '0;
                        r_count <= '0;
                        r_done  <= 1'b0;
                        r_error <= 1'b0;
                        r_busy  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        r_chk   <= '0;
`endif
                    end
                end
                S_WAIT_HI: begin
                    if (bus.i_rx_done) begin
                        r_hi <= bus.i_rx_data;
`ifdef LOADER_CHECKSUM_EN
                        r_chk <= r_chk ^ bus.i_rx_data;
`endif
                        // Unimplemented opcodes abort before anything reaches memory
                        if (w_rx_op > OP_MAX) begin
                            r_state <= S_ERROR;
                            r_busy  <= 1'b0;
                            r_error <= 1'b1;
                        end else begin
                            r_state <= S_WAIT_LO;
                        end
                    end
                end
                S_WAIT_LO: begin
                    if (bus.i_rx_done) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_addr;
                        r_wr_data <= {r_hi, bus.i_rx_data};
                        r_state   <= S_WRITE;
`ifdef LOADER_CHECKSUM_EN
                        r_chk     <= r_chk ^ bus.i_rx_data;
`endif
                    end
                end
                S_WRITE: begin
                    r_count <= r_count + 1'b1;
                    // Address saturates at the top; overflow ends the load instead of wrapping
                    if (r_addr != ADDR_LAST)
                        r_addr <= r_addr + 1'b1;
                    if (bus.i_rx_done) begin
                        r_state <= S_ERROR;
                        r_busy  <= 1'b0;
                        r_error <= 1'b1;
                    end else if (w_hi_op == OP_HALT) begin
`ifdef LOADER_CHECKSUM_EN
                        r_state <= S_CHK;
`else
                        r_state     <= S_DONE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_cpu_start <= 1'b1;
`endif
                    end else if (r_addr == ADDR_LAST) begin
                        r_state <= S_ERROR;
                        r_busy  <= 1'b0;
                        r_error <= 1'b1;
                    end else begin
                        r_state <= S_WAIT_HI;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (bus.i_rx_done) begin
                        r_busy <= 1'b0;
                        if (bus.i_rx_data == r_chk) begin
                            r_state     <= S_DONE;
                            r_done      <= 1'b1;
                            r_cpu_start <= 1'b1;
                        end else begin
                            r_state <= S_ERROR;
                            r_error <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_wr_en   = r_wr_en;
    assign bus.o_wr_addr = r_wr_addr;
    assign bus.o_wr_data = r_wr_data;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_cpu_start   = r_cpu_start;
    assign o_error       = r_error;
    assign o_word_count  = r_count;
endmodule
